// File: rtl/img_pkg.sv
// Shared image-path constants and types for the mapper and the output-memory transmitter.
package img_pkg;

    localparam int NUM_LINES    = 64;
    localparam int PIX_PER_LINE = 16;
    localparam int PIX_W        = 8;
    localparam int DATA_W       = 128;
    localparam int ADDR_W       = 16;
    localparam int MEM_RD_LAT   = 2;
    localparam int LINE_CNT_W   = 7;
    localparam int PIX_IDX_W    = 4;

    localparam logic [ADDR_W-1:0] OUT_MEM_BASE = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/out_line_serializer.sv
// Holds the line currently being transmitted and shifts it out one pixel per handshake,
// reloading from the prefetch buffer so consecutive lines leave no gap.
module out_line_serializer
    import img_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_pf_line,
    input  logic              i_pf_valid,
    input  logic              i_pix_ready,
    output logic [PIX_W-1:0]  o_pix_data,
    output logic              o_pix_valid,
    output logic              o_pix_sol,
    output logic              o_pix_eol,
    output logic              o_pf_load,
    output logic              o_line_done
);

    logic [DATA_W-1:0]    r_cur_line;
    logic                 r_cur_valid;
    logic [PIX_IDX_W-1:0] r_pix_idx;

    logic w_hs;
    logic w_last_pix;

    assign w_hs        = r_cur_valid && i_pix_ready;
    assign w_last_pix  = (r_pix_idx == PIX_IDX_W'(PIX_PER_LINE - 1));
    assign o_line_done = w_hs && w_last_pix;
    // Reload either into an empty slot or in the same cycle the last pixel leaves.
    assign o_pf_load   = i_pf_valid && (!r_cur_valid || o_line_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_line  <= '0;
            r_cur_valid <= 1'b0;
            r_pix_idx   <= '0;
        end else if (o_pf_load) begin
            r_cur_line  <= i_pf_line;
            r_cur_valid <= 1'b1;
            r_pix_idx   <= '0;
        end else if (o_line_done) begin
            r_cur_line  <= r_cur_line >> PIX_W;
            r_cur_valid <= 1'b0;
            r_pix_idx   <= '0;
        end else if (w_hs) begin
            r_cur_line  <= r_cur_line >> PIX_W;
            r_pix_idx   <= r_pix_idx + 1'b1;
        end
    end

    assign o_pix_data  = r_cur_line[PIX_W-1:0];
    assign o_pix_valid = r_cur_valid;
    assign o_pix_sol   = r_cur_valid && (r_pix_idx == '0);
    assign o_pix_eol   = r_cur_valid && w_last_pix;

endmodule

// File: rtl/out_mem_pix_tx.sv
// Reads the mapped frame back from output memory line by line and streams it as
// 8-bit pixels; one prefetched line covers the memory read latency.
module out_mem_pix_tx
    import img_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] out_mem_rd_addr,
    input  logic [DATA_W-1:0] out_mem_rd_data,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sol,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        dbg_state
);

    localparam int RD_LAT = MEM_RD_LAT;

    tx_state_t r_state;
    tx_state_t w_state_nxt;

    logic [LINE_CNT_W-1:0] r_rd_line;
    logic [LINE_CNT_W-1:0] r_tx_line;
    logic [1:0]            r_lat_cnt;
    logic                  r_in_flight;
    logic [DATA_W-1:0]     r_pf_line;
    logic                  r_pf_valid;

    logic w_issue;
    logic w_capture;
    logic w_pf_load;
    logic w_line_done;
    logic w_last_line;
    logic w_frame_end;

    assign w_last_line = (r_tx_line == LINE_CNT_W'(NUM_LINES - 1));
    assign w_frame_end = w_line_done && w_last_line;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_frame_end) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Line 0 is requested on the start edge so its address is on the bus the first busy cycle.
    assign w_issue   = ((r_state == ST_RUN) || ((r_state == ST_IDLE) && start))
                       && (r_rd_line < LINE_CNT_W'(NUM_LINES))
                       && !r_in_flight && !r_pf_valid;
    assign w_capture = r_in_flight && (r_lat_cnt == 2'(RD_LAT));

    always_ff @(posedge clk) begin
        if (reset) begin
            out_mem_rd_addr <= '0;
            r_rd_line       <= '0;
            r_lat_cnt       <= '0;
            r_in_flight     <= 1'b0;
        end else begin
            if (w_issue) begin
                out_mem_rd_addr <= OUT_MEM_BASE + ADDR_W'(r_rd_line);
                r_in_flight     <= 1'b1;
                r_lat_cnt       <= '0;
            end else if (w_capture) begin
                r_in_flight     <= 1'b0;
                r_lat_cnt       <= '0;
                r_rd_line       <= r_rd_line + 1'b1;
            end else if (r_in_flight) begin
                r_lat_cnt       <= r_lat_cnt + 1'b1;
            end
            if (r_state == ST_DONE) r_rd_line <= '0;
        end
    end

    // A capture only follows an issue made with pf empty, so it never meets a load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pf_line  <= '0;
            r_pf_valid <= 1'b0;
        end else if (w_capture) begin
            r_pf_line  <= out_mem_rd_data;
            r_pf_valid <= 1'b1;
        end else if (w_pf_load) begin
            r_pf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                  r_tx_line <= '0;
        else if (r_state == ST_DONE) r_tx_line <= '0;
        else if (w_line_done)       r_tx_line <= r_tx_line + 1'b1;
    end

    out_line_serializer u_ser (
        .clk         (clk),
        .reset       (reset),
        .i_pf_line   (r_pf_line),
        .i_pf_valid  (r_pf_valid),
        .i_pix_ready (pix_ready),
        .o_pix_data  (pix_data),
        .o_pix_valid (pix_valid),
        .o_pix_sol   (pix_sol),
        .o_pix_eol   (pix_eol),
        .o_pf_load   (w_pf_load),
        .o_line_done (w_line_done)
    );

    assign pix_eof    = pix_eol && w_last_line;
    assign busy       = (r_state == ST_RUN);
    assign frame_done = (r_state == ST_DONE);
    assign dbg_state  = r_state;

endmodule
